simple_alu_share_arbiter: RTL

- Shares one combinational Simple ALU between two issue lanes (e.g. two simple-ALU issue ports from the issue queue).
- Each lane has a one-entry holding buffer with a registered ready signal.
- A round-robin arbiter selects one held packet per cycle and drives it into the ALU.
- The ALU's wbPkt is captured in a single output register with valid/ready backpressure toward the writeback bus. The block sits between issue/register-read and the writeback/bypass stage.

---
 rtl/simple_alu_share_arbiter_pkg.sv | 37 +++
 rtl/simple_alu_share_arbiter_if.sv | 36 +++
 rtl/simple_alu_share_arbiter_alu_lane_buffer.sv | 38 +++
 rtl/simple_alu_share_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/simple_alu_share_arbiter_pkg.sv
// Shared types for the two-lane simple-ALU share arbiter: lane indexing, FU issue packet and writeback packet.
package simple_alu_share_arbiter_pkg;

    localparam int unsigned SIMPLE_ALU_LANES = 2;
    localparam int unsigned LANE_W           = 1;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned TAG_W            = 4;

    typedef logic [LANE_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic              valid;
        alu_op_e           op;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
    } fu_pkt_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] dest_data;
    } wb_pkt_t;

    // Round-robin partner of the lane that won last.
    function automatic lane_idx_t other_lane(input lane_idx_t lane);
        return ~lane;
    endfunction

endpackage

// File: rtl/simple_alu_share_arbiter_if.sv
// Issue-side, ALU-side and writeback-side signals of the share arbiter bundled as one interface.
interface simple_alu_share_arbiter_if #(
    parameter int unsigned CNT_W = 32
);
    import simple_alu_share_arbiter_pkg::*;

    logic             flush_i;
    logic             req0_valid_i;
    fu_pkt_t          req0_pkt_i;
    logic             req0_ready_o;
    logic             req1_valid_i;
    fu_pkt_t          req1_pkt_i;
    logic             req1_ready_o;
    fu_pkt_t          alu_pkt_o;
    wb_pkt_t          alu_wb_i;
    logic             wb_valid_o;
    wb_pkt_t          wb_pkt_o;
    logic             wb_ready_i;
    logic [CNT_W-1:0] busy_cnt_o;
    logic [CNT_W-1:0] conflict_cnt_o;

    modport slave (
        input  flush_i, req0_valid_i, req0_pkt_i, req1_valid_i, req1_pkt_i,
               alu_wb_i, wb_ready_i,
        output req0_ready_o, req1_ready_o, alu_pkt_o, wb_valid_o, wb_pkt_o,
               busy_cnt_o, conflict_cnt_o
    );

    modport master (
        output flush_i, req0_valid_i, req0_pkt_i, req1_valid_i, req1_pkt_i,
               alu_wb_i, wb_ready_i,
        input  req0_ready_o, req1_ready_o, alu_pkt_o, wb_valid_o, wb_pkt_o,
               busy_cnt_o, conflict_cnt_o
    );

endinterface

// File: rtl/simple_alu_share_arbiter_alu_lane_buffer.sv
// One-entry holding register for an issue lane; ready is the inverted occupancy flop.
module simple_alu_share_arbiter_alu_lane_buffer
    import simple_alu_share_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    flush,
    input  logic    valid,
    input  fu_pkt_t pkt,
    input  logic    grant,
    output logic    ready,
    output logic    held,
    output fu_pkt_t held_pkt
);

    logic    hold_v;
    fu_pkt_t hold_pkt;

    // Accept only when empty, so accept and grant never coincide on one lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_v   <= 1'b0;
            hold_pkt <= '0;
        end else if (flush) begin
            hold_v <= 1'b0;
        end else if (valid && !hold_v) begin
            hold_v   <= 1'b1;
            hold_pkt <= pkt;
        end else if (grant) begin
            hold_v <= 1'b0;
        end
    end

    assign ready    = !hold_v;
    assign held     = hold_v;
    assign held_pkt = hold_pkt;

endmodule

// File: rtl/simple_alu_share_arbiter.sv
// Shares one combinational simple ALU between two issue lanes with round-robin grant
// and a single backpressured writeback register.
module simple_alu_share_arbiter
    import simple_alu_share_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic                      clk,
    input logic                      reset_n,
    simple_alu_share_arbiter_if.slave bus
);

    logic [SIMPLE_ALU_LANES-1:0] hold_v;
    logic [SIMPLE_ALU_LANES-1:0] lane_grant;
    fu_pkt_t                     held_pkt0;
    fu_pkt_t                     held_pkt1;

    logic             out_v;
    wb_pkt_t          out_pkt;
    lane_idx_t        last_grant;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] conflict_cnt;

    logic      can_grant;
    logic      both_held;
    logic      grant_v;
    lane_idx_t grant_lane;

    simple_alu_share_arbiter_alu_lane_buffer u_lane0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (bus.flush_i),
        .valid    (bus.req0_valid_i),
        .pkt      (bus.req0_pkt_i),
        .grant    (lane_grant[0]),
        .ready    (bus.req0_ready_o),
        .held     (hold_v[0]),
        .held_pkt (held_pkt0)
    );

    simple_alu_share_arbiter_alu_lane_buffer u_lane1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (bus.flush_i),
        .valid    (bus.req1_valid_i),
        .pkt      (bus.req1_pkt_i),
        .grant    (lane_grant[1]),
        .ready    (bus.req1_ready_o),
        .held     (hold_v[1]),
        .held_pkt (held_pkt1)
    );

    assign can_grant = !out_v || bus.wb_ready_i;
    assign both_held = hold_v[0] && hold_v[1];

    // Round-robin pick; a flush cycle never grants.
    always_comb begin
        grant_v    = 1'b0;
        grant_lane = '0;
        if (!bus.flush_i && can_grant) begin
            if (both_held) begin
                grant_v    = 1'b1;
                grant_lane = other_lane(last_grant);
            end else if (hold_v[0]) begin
                grant_v    = 1'b1;
                grant_lane = 1'b0;
            end else if (hold_v[1]) begin
                grant_v    = 1'b1;
                grant_lane = 1'b1;
            end
        end
    end

    always_comb begin
        lane_grant    = '0;
        bus.alu_pkt_o = '0;
        if (grant_v) begin
            lane_grant[grant_lane] = 1'b1;
            bus.alu_pkt_o          = (grant_lane == 1'b1) ? held_pkt1 : held_pkt0;
        end
    end

    // Output register: a grant overwrites even while draining, keeping one result per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_v      <= 1'b0;
            out_pkt    <= '0;
            last_grant <= 1'b1;
        end else if (bus.flush_i) begin
            out_v <= 1'b0;
        end else if (grant_v) begin
            out_v      <= 1'b1;
            out_pkt    <= bus.alu_wb_i;
            last_grant <= grant_lane;
        end else if (bus.wb_ready_i) begin
            out_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_cnt     <= '0;
            conflict_cnt <= '0;
        end else if (grant_v) begin
            if (busy_cnt != '1) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
            if (both_held && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.wb_valid_o     = out_v;
    assign bus.wb_pkt_o       = out_pkt;
    assign bus.busy_cnt_o     = busy_cnt;
    assign bus.conflict_cnt_o = conflict_cnt;

endmodule
